// File: rtl/button_pulse_gen.sv
// button_pulse_gen: turns a raw, bouncing push-button level into a debounced
// level (held) plus one-cycle strobes on each accepted press (pulse) and
// release (released). All outputs are registered; btn_in only reaches the
// FSM through a two-flop synchronizer.
module button_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic held,
  output logic released
);

  // Last counter value before a check state accepts the new level.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHECK,
    ST_HELD,
    ST_RELEASE_CHECK
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 s1;
  logic                 s2;
  logic                 pulse_nxt;
  logic                 held_nxt;
  logic                 released_nxt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pulse    <= 1'b0;
      held     <= 1'b0;
      released <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pulse    <= pulse_nxt;
      held     <= held_nxt;
      released <= released_nxt;
    end
  end

  // Next-state logic; counter is compared before incrementing so it never wraps.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pulse_nxt    = 1'b0;
    released_nxt = 1'b0;
    held_nxt     = held;

    case (state)
      ST_IDLE: begin
        held_nxt = 1'b0;
        if (s2) begin
          state_nxt = ST_PRESS_CHECK;
          cnt_nxt   = '0;
        end
      end

      ST_PRESS_CHECK: begin
        held_nxt = 1'b0;
        if (!s2) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          pulse_nxt = 1'b1;
          held_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end

      ST_HELD: begin
        held_nxt = 1'b1;
        if (!s2) begin
          state_nxt = ST_RELEASE_CHECK;
          cnt_nxt   = '0;
        end
      end

      ST_RELEASE_CHECK: begin
        held_nxt = 1'b1;
        if (s2) begin
          state_nxt = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = ST_IDLE;
          released_nxt = 1'b1;
          held_nxt     = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        held_nxt  = 1'b0;
      end
    endcase
  end

endmodule
